// File: rtl/img_stream_tx_if.sv
// Word stream into the core: valid/data from the transmitter, ready back from the core.
interface img_stream_tx_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/img_stream_tx.sv
// Streams an image from a byte-wide SRAM as packed 32-bit words, then three weight words.
// Define IMG_TX_CHKSUM_EN to build a running XOR checksum of all transferred words.
module img_stream_tx #(
    parameter int IMG_BYTES = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [71:0]       i_weights,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_cen,
    input  logic [7:0]        i_sram_q,
    img_stream_tx_if.master   stream,
    output logic              o_busy,
    output logic              o_img_done,
    output logic              o_done,
    output logic [31:0]       o_chksum
);
    // state  | meaning
    // S_IDLE | waiting for start, SRAM disabled
    // S_IMG  | fetching bytes, packing and sending image words
    // S_WGT  | sending the three weight words
    // S_DONE | one-cycle completion state before IDLE
    typedef enum logic [1:0] {S_IDLE, S_IMG, S_WGT, S_DONE} state_t;

    localparam int                WORDS     = IMG_BYTES / 4;
    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  RD_END    = CNT_W'(IMG_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

    state_t            state;
    logic [CNT_W-1:0]  rd_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic [3:0]        credit;
    logic [3:0]        credit_after;
    logic [3:0]        credit_next;
    logic              rd_vld;
    logic [31:0]       pack_data;
    logic [2:0]        pack_cnt;
    logic [2:0]        pack_base;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [1:0]        wgt_idx;
    logic [71:0]       w_reg;
    logic              hs;
    logic              img_hs;
    logic              pack_mv;
    logic              issue;

    // credit counts bytes read but not yet handed off; 8 bytes fill pack + output registers
    always_comb begin
        hs           = out_valid && stream.in_ready && !i_abort && !i_rst;
        img_hs       = hs && (state == S_IMG);
        pack_mv      = (pack_cnt == 3'd4) && (!out_valid || hs);
        credit_after = img_hs ? (credit - 4'd4) : credit;
        issue        = (state == S_IMG) && (rd_cnt < RD_END) && (credit_after < 4'd8);
        credit_next  = credit_after + {3'b000, issue};
        pack_base    = pack_mv ? 3'd0 : pack_cnt;
    end

    assign stream.in_valid = out_valid;
    assign stream.in_data  = out_data;
    assign o_busy          = (state != S_IDLE);
    assign o_img_done      = img_hs && (word_cnt == LAST_WORD);
    assign o_done          = hs && (state == S_WGT) && (wgt_idx == 2'd2);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            rd_cnt      <= '0;
            word_cnt    <= '0;
            credit      <= '0;
            rd_vld      <= 1'b0;
            pack_data   <= '0;
            pack_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            wgt_idx     <= '0;
            w_reg       <= '0;
            o_sram_addr <= '0;
            o_sram_cen  <= 1'b1;
        end else if (i_abort) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            o_sram_cen <= 1'b1;
            rd_vld     <= 1'b0;
            pack_cnt   <= '0;
            credit     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rd_vld     <= 1'b0;
                    o_sram_cen <= 1'b1;
                    if (i_start) begin
                        state       <= S_IMG;
                        w_reg       <= i_weights;
                        word_cnt    <= '0;
                        pack_cnt    <= '0;
                        o_sram_addr <= '0;
                        o_sram_cen  <= 1'b0;
                        rd_cnt      <= CNT_W'(1);
                        credit      <= 4'd1;
                    end
                end
                S_IMG: begin
                    rd_vld     <= !o_sram_cen;
                    o_sram_cen <= !issue;
                    credit     <= credit_next;
                    if (issue) begin
                        o_sram_addr <= rd_cnt[ADDR_W-1:0];
                        rd_cnt      <= rd_cnt + 1'b1;
                    end
                    // bytes shift in from the right so the first byte lands in [31:24]
                    if (rd_vld)
                        pack_data <= {pack_data[23:0], i_sram_q};
                    pack_cnt <= pack_base + {2'b00, rd_vld};
                    if (pack_mv) begin
                        out_valid <= 1'b1;
                        out_data  <= pack_data;
                    end else if (hs) begin
                        out_valid <= 1'b0;
                    end
                    if (hs) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            state     <= S_WGT;
                            out_valid <= 1'b1;
                            out_data  <= w_reg[71:40];
                            wgt_idx   <= 2'd0;
                        end
                    end
                end
                S_WGT: begin
                    rd_vld     <= 1'b0;
                    o_sram_cen <= 1'b1;
                    if (hs) begin
                        if (wgt_idx == 2'd2) begin
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                        end else begin
                            wgt_idx  <= wgt_idx + 1'b1;
                            out_data <= (wgt_idx == 2'd0) ? w_reg[39:8] : {w_reg[7:0], 24'h000000};
                        end
                    end
                end
                S_DONE: begin
                    o_sram_cen <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IMG_TX_CHKSUM_EN
    logic [31:0] chk;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            chk <= '0;
        else if ((state == S_IDLE) && i_start && !i_abort)
            chk <= '0;
        else if (hs)
            chk <= chk ^ out_data;
    end

    assign o_chksum = chk;
`else
    assign o_chksum = 32'h0;
`endif
endmodule

// File: tb/tb_img_stream_tx.sv
// Self-checking bench for img_stream_tx with a byte SRAM model and a word-level reference list.
module tb_img_stream_tx;
    localparam int IMG_BYTES = 4096;
    localparam int ADDR_W    = 12;
    localparam int WORDS     = IMG_BYTES / 4;
    localparam int NEXP      = WORDS + 3;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [71:0] weights;
    logic [11:0] sram_addr;
    logic        sram_cen;
    logic [7:0]  sram_q;
    logic        busy, img_done, done;
    logic [31:0] chksum;

    img_stream_tx_if bus();

    img_stream_tx #(.IMG_BYTES(IMG_BYTES), .ADDR_W(ADDR_W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_weights  (weights),
        .o_sram_addr(sram_addr),
        .o_sram_cen (sram_cen),
        .i_sram_q   (sram_q),
        .stream     (bus),
        .o_busy     (busy),
        .o_img_done (img_done),
        .o_done     (done),
        .o_chksum   (chksum)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [IMG_BYTES];
    always @(posedge clk) if (!sram_cen) sram_q <= mem[sram_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_w [NEXP];
    logic [31:0] got_w [NEXP];
    int          hs_time [NEXP];
    int          exp_idx, rd_cnt, img_hs_cnt, nedge;
    bit          img_done_seen, done_seen, mon_en;
    logic        prev_valid, prev_ready, prev_abort, prev_rst, mon_hs;
    logic [31:0] prev_data;

    initial begin
        exp_idx = 0; rd_cnt = 0; img_hs_cnt = 0; nedge = 0;
        img_done_seen = 0; done_seen = 0; mon_en = 0;
        prev_valid = 0; prev_ready = 0; prev_abort = 0; prev_rst = 1; prev_data = 0;
    end

    always @(negedge clk) begin
        nedge++;
        if (mon_en) begin
            mon_hs = bus.in_valid && bus.in_ready && !abort && !rst;
            if (prev_valid && !prev_ready && !prev_abort && !prev_rst) begin
                check("hold_valid", bus.in_valid, 1);
                check("hold_data", bus.in_data, prev_data);
            end
            if (sram_cen === 1'b0) begin
                check("rd_addr", sram_addr, rd_cnt[11:0]);
                check("rd_range", rd_cnt < IMG_BYTES, 1);
                rd_cnt++;
                check("prefetch", (rd_cnt - 4 * img_hs_cnt) <= 8, 1);
            end
            if (!busy) check("idle_cen", sram_cen, 1);
            if (mon_hs) begin
                if (exp_idx < NEXP) begin
                    check("word", bus.in_data, exp_w[exp_idx]);
                    check("img_done", img_done, exp_idx == WORDS - 1);
                    check("done", done, exp_idx == NEXP - 1);
                    got_w[exp_idx]   = bus.in_data;
                    hs_time[exp_idx] = nedge;
                    if (exp_idx == WORDS - 1) img_done_seen = 1;
                    if (exp_idx == NEXP - 1) done_seen = 1;
                    if (exp_idx < WORDS) img_hs_cnt++;
                end else begin
                    check("word_count", exp_idx, NEXP - 1);
                end
                exp_idx++;
            end else begin
                check("no_pulse", {img_done, done}, 2'b00);
            end
        end
        prev_valid = bus.in_valid;
        prev_ready = bus.in_ready;
        prev_abort = abort;
        prev_rst   = rst;
        prev_data  = bus.in_data;
    end

    task automatic build_exp();
        for (int k = 0; k < WORDS; k++)
            exp_w[k] = {mem[4*k], mem[4*k+1], mem[4*k+2], mem[4*k+3]};
        exp_w[WORDS]   = weights[71:40];
        exp_w[WORDS+1] = weights[39:8];
        exp_w[WORDS+2] = {weights[7:0], 24'h000000};
    endtask

    function automatic logic [31:0] xor_all();
        logic [31:0] x = 32'h0;
        for (int k = 0; k < NEXP; k++) x ^= exp_w[k];
        return x;
    endfunction

    task automatic do_start();
        @(posedge clk); #1;
        exp_idx = 0; rd_cnt = 0; img_hs_cnt = 0; img_done_seen = 0; done_seen = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic run_stream(input int mode, input int budget);
        int t = 0;
        bit stalled = 0;
        int stall_left = 0;
        while (!done_seen && t < budget) begin
            @(posedge clk); #1;
            t++;
            if (mode == 1) begin
                if (!stalled && img_hs_cnt >= 200 && bus.in_valid) begin
                    stalled = 1;
                    stall_left = 20;
                end
                if (stall_left > 0) begin
                    bus.in_ready = 0;
                    stall_left--;
                end else begin
                    bus.in_ready = ($urandom_range(0, 99) < 30);
                end
            end
        end
        check("done_in_budget", done_seen, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, bus.in_valid, 0);
        check({tag, "_data"}, bus.in_data, 0);
        check({tag, "_cen"}, sram_cen, 1);
        check({tag, "_addr"}, sram_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_img_done"}, img_done, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_chksum"}, chksum, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int bad;
        logic [31:0] exp_chk;
        rst = 1; start = 0; abort = 0; weights = '0; bus.in_ready = 0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_reset_vals("reset");
        mon_en = 1;

        // Full stream, ready high, byte n = n[7:0]
        for (int n = 0; n < IMG_BYTES; n++) mem[n] = 8'(n);
        weights = 72'h010203040506070809;
        build_exp();
        bus.in_ready = 1;
        do_start();
        for (int n = 0; n <= 6; n++) begin
            @(negedge clk);
            if (n == 0) begin
                check("first_cen", sram_cen, 0);
                check("first_addr", sram_addr, 0);
            end
            check("first_valid", bus.in_valid, n == 6);
        end
        run_stream(0, 6000);
        check("w0", got_w[0], 32'h00010203);
        check("w1", got_w[1], 32'h04050607);
        check("w1023", got_w[WORDS-1], 32'hFCFDFEFF);
        check("wgt0", got_w[WORDS], 32'h01020304);
        check("wgt1", got_w[WORDS+1], 32'h05060708);
        check("wgt2", got_w[WORDS+2], 32'h09000000);
        check("reads_total", rd_cnt, IMG_BYTES);
        bad = 0;
        for (int k = 1; k < WORDS; k++) if (hs_time[k] - hs_time[k-1] != 4) bad++;
        check("img_spacing", bad, 0);
        check("wgt_gap", hs_time[WORDS] - hs_time[WORDS-1], 1);
        check("done_gap", hs_time[WORDS+2] - hs_time[WORDS-1], 3);
`ifdef IMG_TX_CHKSUM_EN
        exp_chk = xor_all();
`else
        exp_chk = 32'h0;
`endif
        @(negedge clk);
        check("busy_done_state", busy, 1);
        check("chk_full", chksum, exp_chk);
        @(negedge clk);
        check("busy_idle", busy, 0);
        check("chk_hold", chksum, exp_chk);

        // Backpressure: random ready with a 20-cycle stall mid-word
        for (int n = 0; n < IMG_BYTES; n++) mem[n] = 8'($urandom());
        weights = {$urandom(), $urandom(), 8'($urandom())};
        build_exp();
        do_start();
        run_stream(1, 20000);
        check("bp_words", exp_idx, NEXP);
        check("bp_reads", rd_cnt, IMG_BYTES);

        // Decode gap after last image word
        for (int n = 0; n < IMG_BYTES; n++) mem[n] = 8'(n);
        weights = 72'h010203040506070809;
        build_exp();
        bus.in_ready = 1;
        do_start();
        t = 0;
        while (!img_done_seen && t < 6000) begin
            @(posedge clk); #1;
            t++;
        end
        bus.in_ready = 0;
        check("gap_reached", img_done_seen, 1);
        repeat (50) begin
            @(negedge clk);
            check("gap_valid", bus.in_valid, 1);
            check("gap_data", bus.in_data, 32'h01020304);
        end
        @(posedge clk); #1;
        bus.in_ready = 1;
        run_stream(0, 100);
        check("gap_words", exp_idx, NEXP);

        // Abort at word 100 with valid high and ready low, then restart
        do_start();
        t = 0;
        while (img_hs_cnt < 100 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        bus.in_ready = 0;
        t = 0;
        while (!bus.in_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_setup", bus.in_valid, 1);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        check("abort_valid", bus.in_valid, 0);
        check("abort_cen", sram_cen, 1);
        check("abort_busy", busy, 0);
        check("abort_words", exp_idx, 100);
        bus.in_ready = 1;
        do_start();
        run_stream(0, 6000);
        check("restart_w0", got_w[0], 32'h00010203);
        check("restart_words", exp_idx, NEXP);

        // All-0xAA image: checksum reduces to the weight words
        for (int n = 0; n < IMG_BYTES; n++) mem[n] = 8'hAA;
        weights = {$urandom(), $urandom(), 8'($urandom())};
        build_exp();
        do_start();
        run_stream(0, 6000);
`ifdef IMG_TX_CHKSUM_EN
        exp_chk = weights[71:40] ^ weights[39:8] ^ {weights[7:0], 24'h000000};
`else
        exp_chk = 32'h0;
`endif
        @(negedge clk);
        check("chk_aa", chksum, exp_chk);

        // Reset mid-stream
        do_start();
        t = 0;
        while (img_hs_cnt < 50 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_reset_vals("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/img_stream_tx.md
# img_stream_tx

Transmit side of the core's 32-bit image/weight input protocol. Reads a 4096-byte image from a source `sram_4096x8`, packs four pixels per word and streams them over a valid/ready handshake. It then sends the nine convolution weights as three words. It sits in the test harness and in the system shell in front of the core, driving `i_in_valid`/`i_in_data` and observing `o_in_ready`.

## Interface
- `IMG_BYTES`, default 4096: image size in bytes; must be a multiple of 4.
- `ADDR_W`, default 12: source SRAM address width.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: start pulse; sampled only in IDLE.
- `i_abort` in 1: return to IDLE from any state.
- `i_weights` in 72: w0..w8, w0 in [71:64]; latched on accepted start.
- `o_sram_addr` out ADDR_W: source read address.
- `o_sram_cen` out 1: chip enable, active low.
- `i_sram_q` in 8: read data, valid one cycle after the CEN=0 edge.
- `o_in_valid` out 1: word valid (to core `i_in_valid`).
- `o_in_data` out 32: packed word (to core `i_in_data`).
- `i_in_ready` in 1: core `o_in_ready`.
- `o_busy` out 1: high in every state except IDLE.
- `o_img_done` out 1: one-cycle pulse on the handshake of the last image word.
- `o_done` out 1: one-cycle pulse on the handshake of the last weight word.
- `o_chksum` out 32: see Configuration.

## Operation
- **States:** IDLE, IMG, WGT, DONE.
- **IDLE → IMG:** on `i_start`. Clears the read pointer and word counter and latches `i_weights`.
- **IMG:** runs a fetch engine and two word registers.
  - The fetch engine issues one read per cycle (CEN=0) at addresses 0,1,2,… whenever the pack register is free or will be freed this cycle.
  - Returned bytes are placed into the pack register MSB-first: byte 4k at [31:24], 4k+1 at [23:16], 4k+2 at [15:8], 4k+3 at [7:0].
  - A full pack register moves to the output register when the output register is empty or handshaking in the same cycle.
  - The fetch engine stalls (CEN=1, address held) when both registers are full and there is no handshake.
  - No read is issued past address IMG_BYTES-1.
- **IMG → WGT:** on the handshake of word IMG_BYTES/4-1. `o_img_done` pulses in that cycle.
- **WGT:** sends three words in order:
  - {w0,w1,w2,w3}
  - {w4,w5,w6,w7}
  - {w8,24'h0}
- **Weight timing:** weight word 0 appears in the output register in the cycle after the last image handshake. It is held while the core decodes with ready low.
- **WGT → DONE:** on the third weight handshake. `o_done` pulses in that cycle.
- **DONE → IDLE:** next cycle.
- **Handshake:** a transfer occurs when `o_in_valid && i_in_ready`.
  - While `o_in_valid=1` and `i_in_ready=0`, `o_in_data` and `o_in_valid` hold.
  - `o_in_valid` never depends combinationally on `i_in_ready`.
- **Abort:** `i_abort` in any state sends the block to IDLE on the next edge. Pending words are dropped, `o_in_valid=0`, `o_sram_cen=1`. `i_abort` takes priority over `i_start` and over a same-cycle handshake; no done pulse is generated. Abort is used when the core reports an invalid barcode and never asks for weights.
- **Busy:** `i_start` while not IDLE is ignored.

## Timing
- **Reset values:** state IDLE, `o_in_valid=0`, `o_in_data=0`, `o_sram_cen=1`, `o_sram_addr=0`, `o_busy=0`, `o_img_done=0`, `o_done=0`, `o_chksum=0`, all pointers 0.
- **Reset priority:** synchronous reset mid-transfer overrides everything. The state after the edge equals the reset values.
- **First-word latency:** with `i_start` at edge 0, reads of addresses 0..3 occur at edges 1..4 and data arrives at edges 2..5. Word 0 has `o_in_valid=1` after edge 6.
- **Throughput:** with ready held high, one image word every 4 cycles, sustained; fetch of word k+1 overlaps the presentation of word k.
- **Transfer length:** with ready held high, image + weights takes 6 + 4·(IMG_BYTES/4-1) + 3 cycles from start to the `o_done` edge.
- **Prefetch bound:** the fetch engine never issues more reads than two-word buffering can absorb.

## Configuration
- **`IMG_TX_CHKSUM_EN` defined:** `o_chksum` is the running XOR of every handshaken word, image and weights. It is cleared on accepted start and holds after DONE until the next start or reset.
- **`IMG_TX_CHKSUM_EN` undefined:** `o_chksum` is tied to 0 and no checksum register is built.

## Test plan
- **Reset:** assert `i_rst` for 2 cycles → all outputs at reset values; `o_sram_cen=1`.
- **Full stream, ready high:** source SRAM byte n = n[7:0]; `i_start`, ready high →
  - first word 0x00010203, second word 0x04050607;
  - word 1023 is 0xFCFDFEFF, with `o_img_done` on it;
  - weights 0x0102…09 give 0x01020304, 0x05060708, 0x09000000, with `o_done` on the third.
- **Backpressure:** random ready (~30% duty), with ready low for 20 cycles mid-word → data held stable; no skipped or duplicated word; SRAM address sequence monotonic without gaps.
- **Decode gap:** after the last image word, hold ready low for 50 cycles → `o_in_valid=1` with 0x01020304 held throughout; then ready high completes the weights.
- **Abort:** `i_abort` at word 100 while valid high and ready low → IDLE next cycle, `o_in_valid=0`; a new `i_start` restarts from address 0.
- **Checksum (macro on):** the all-0xAA image XORs to 0 over its even word count, so `o_chksum` = XOR of the three weight words; reset mid-stream → 0.
